con_dump_sequencer: RTL and testbench
=====================================

# con_dump_sequencer

Synthesizable halt detector and data-memory dump engine attached to the RV32IMC core's console port. It watches the fetch-stage instruction stream until the program has settled, which it treats as a halt. It then walks `con_addr` from 0 to `MAX_ADDR`, reads each word from `con_out`, and emits the words as a byte stream followed by a 32-bit additive checksum. The byte stream uses a valid/ready handshake and feeds the UART TX buffer. This lets a board run be checked against the answer key without a simulator.

## Interface
- `ADDR_W`, 14: width of `con_addr`.
- `MAX_ADDR`, 783: last word address dumped (inclusive).
- `STALL_LIMIT`, 49: count of consecutive repeated instructions that declares a halt.
- `NOP_LIMIT`, 16: count of consecutive repeated NOPs that declares a halt.
- `RD_LAT`, 1: cycles from a `con_addr` change until `con_out` is valid (≥1).

Ports:
- `clk`  in  1  core clock; all logic on the rising edge.
- `nrst`  in  1  reset, asynchronous and active-low.
- `if_inst`  in  32  fetch-stage instruction, sampled every cycle.
- `con_addr`  out  ADDR_W  word address into data memory console port.
- `con_out`  in  32  word read from `con_addr`.
- `out_data`  out  8  stream byte.
- `out_valid`  out  1  `out_data` holds a byte.
- `out_ready`  in  1  sink accepts the byte this cycle.
- `halted`  out  1  sticky; set when halt is detected.
- `dump_busy`  out  1  high while in ADDR/WAIT/SEND/CSUM.
- `dump_done`  out  1  sticky; set after the last checksum byte is accepted.

## Operation
- Reset values: `con_addr`=0, `out_data`=0, `out_valid`=0, `halted`=0, `dump_busy`=0, `dump_done`=0. Internal `last_inst`=0, both counters 0, checksum 0, state MON.
- NOP definition: `if_inst[15:0]==16'h0001` (c.nop) or `if_inst==32'h00000013`.
- MON, evaluated every edge:
  - If `if_inst==last_inst`: `same_cnt`+1; also `nop_cnt`+1 if the instruction is a NOP, else `nop_cnt`=0.
  - Otherwise: `last_inst`<=`if_inst`, both counters=0.
  - Counters saturate at their limits.
- Halt: on the edge where `same_cnt` becomes `STALL_LIMIT` or `nop_cnt` becomes `NOP_LIMIT`, `halted`<=1 and the state goes to ADDR.
- ADDR: `con_addr` holds the current address. Go to WAIT and load the latency counter with `RD_LAT`.
- WAIT: decrement the counter. On the edge where it reaches 0:
  - Capture `con_out` into the word register.
  - `checksum` += `con_out` (mod 2^32).
  - Go to SEND with byte index 3.
- SEND: present the word MSB first (`[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`), one byte per accepted handshake. After byte index 0 is accepted:
  - If `con_addr==MAX_ADDR`: go to CSUM.
  - Otherwise: `con_addr`+1, go to ADDR.
- CSUM: send the checksum MSB first, 4 bytes. After the last accept: `dump_done`<=1, `out_valid`<=0, go to DONE.
- DONE: terminal. `con_addr` holds `MAX_ADDR`. `if_inst` is ignored. Only `nrst` leaves DONE.
- Stream length: 4·(`MAX_ADDR`+1)+4 bytes.

## Timing
- `halted` is visible the cycle after the limit-reaching edge. `dump_busy` rises on that same edge.
- Latency from the halt edge to the first `out_valid`: 1 (ADDR) + `RD_LAT` (WAIT) edges. `out_valid`/`out_data` are registered.
- Handshake: a transfer occurs on an edge where `out_valid && out_ready`.
- While `out_valid && !out_ready`, `out_data` is held stable and `out_valid` stays high.
- The next byte appears on the edge after an accept. At most one byte moves per cycle.
- Between words, `out_valid` drops for 1+`RD_LAT` cycles.
- `con_addr` changes only on the ADDR-entry edge. It never changes while SEND is waiting on `out_ready`.
- `if_inst` is not sampled once `halted`=1.
- `nrst` deasserted mid-dump: all state returns to reset values immediately (asynchronous). A partially sent word is discarded and monitoring restarts from MON.

## Test plan
- Reset released, `if_inst` increments by 4 every cycle for 1000 cycles -> `halted`=0, `out_valid` never high.
- `if_inst`=0x00000013 held from the first edge after release -> edge 1 loads `last_inst`; `halted`=1 after edge 17; `dump_busy`=1 after edge 17.
- `if_inst`=0x0000006F (jal x0,0) held -> `halted`=1 after edge 50. The pattern 0x13,0x13,0x6F repeated never halts.
- `MAX_ADDR`=2, memory model words 0x11223344, 0xA5A5A5A5, 0x00000001, `RD_LAT`=2, `out_ready`=1 -> stream 11 22 33 44 A5 A5 A5 A5 00 00 00 01 B6 C7 D8 EA; then `dump_done`=1.
- Same setup with `out_ready` toggled pseudo-randomly -> identical 16-byte stream, `out_data` stable across every stall, no `con_addr` change during stalls.
- `nrst` pulsed low after the 6th accepted byte -> all outputs 0 at once; after release and a new halt, the full stream restarts from 11.

Source files
------------

// File: rtl/con_dump_sequencer_if.sv
// Console-port and byte-stream signals between the dump sequencer and its neighbours.
// master = sequencer side; slave = memory console port plus UART TX buffer side.
interface con_dump_sequencer_if #(
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] con_addr;
  logic [31:0]       con_out;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output con_addr, out_data, out_valid,
    input  con_out, out_ready
  );

  modport slave (
    input  con_addr, out_data, out_valid,
    output con_out, out_ready
  );
endinterface

// File: rtl/con_dump_sequencer.sv
// Halt detector on the fetch stream followed by a data-memory dump.
// Each word goes out MSB first, then a 32-bit additive checksum.
module con_dump_sequencer #(
  parameter int ADDR_W      = 14,
  parameter int MAX_ADDR    = 783,
  parameter int STALL_LIMIT = 49,
  parameter int NOP_LIMIT   = 16,
  parameter int RD_LAT      = 1
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [31:0]          if_inst,
  con_dump_sequencer_if.master bus,
  output logic                 halted,
  output logic                 dump_busy,
  output logic                 dump_done
);

  localparam int SAME_W = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);
  localparam int NOP_W  = (NOP_LIMIT < 2)   ? 1 : $clog2(NOP_LIMIT + 1);
  localparam int LAT_W  = (RD_LAT < 2)      ? 1 : $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {
    S_MON, S_ADDR, S_WAIT, S_SEND, S_CSUM, S_DONE
  } state_t;

  state_t            r_state,     w_state_next;
  logic [31:0]       r_last_inst, w_last_inst_next;
  logic [SAME_W-1:0] r_same_cnt,  w_same_cnt_next;
  logic [NOP_W-1:0]  r_nop_cnt,   w_nop_cnt_next;
  logic [LAT_W-1:0]  r_lat_cnt,   w_lat_cnt_next;
  logic [1:0]        r_byte_idx,  w_byte_idx_next;
  logic [31:0]       r_shift,     w_shift_next;
  logic [31:0]       r_csum,      w_csum_next;
  logic [ADDR_W-1:0] r_addr,      w_addr_next;
  logic [7:0]        r_out_data,  w_out_data_next;
  logic              r_out_valid, w_out_valid_next;
  logic              r_halted,    w_halted_next;
  logic              r_done,      w_done_next;

  logic w_is_nop;
  logic w_same_inst;
  logic w_accept;

  assign w_is_nop    = (if_inst[15:0] == 16'h0001) || (if_inst == 32'h0000_0013);
  assign w_same_inst = (if_inst == r_last_inst);
  assign w_accept    = r_out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= S_MON;
      r_last_inst <= '0;
      r_same_cnt  <= '0;
      r_nop_cnt   <= '0;
      r_lat_cnt   <= '0;
      r_byte_idx  <= '0;
      r_shift     <= '0;
      r_csum      <= '0;
      r_addr      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_halted    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_last_inst <= w_last_inst_next;
      r_same_cnt  <= w_same_cnt_next;
      r_nop_cnt   <= w_nop_cnt_next;
      r_lat_cnt   <= w_lat_cnt_next;
      r_byte_idx  <= w_byte_idx_next;
      r_shift     <= w_shift_next;
      r_csum      <= w_csum_next;
      r_addr      <= w_addr_next;
      r_out_data  <= w_out_data_next;
      r_out_valid <= w_out_valid_next;
      r_halted    <= w_halted_next;
      r_done      <= w_done_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_last_inst_next = r_last_inst;
    w_same_cnt_next  = r_same_cnt;
    w_nop_cnt_next   = r_nop_cnt;
    w_lat_cnt_next   = r_lat_cnt;
    w_byte_idx_next  = r_byte_idx;
    w_shift_next     = r_shift;
    w_csum_next      = r_csum;
    w_addr_next      = r_addr;
    w_out_data_next  = r_out_data;
    w_out_valid_next = r_out_valid;
    w_halted_next    = r_halted;
    w_done_next      = r_done;

    case (r_state)
      S_MON: begin
        if (w_same_inst) begin
          if (r_same_cnt != SAME_W'(STALL_LIMIT))
            w_same_cnt_next = r_same_cnt + SAME_W'(1);
          if (!w_is_nop)
            w_nop_cnt_next = '0;
          else if (r_nop_cnt != NOP_W'(NOP_LIMIT))
            w_nop_cnt_next = r_nop_cnt + NOP_W'(1);
        end else begin
          w_last_inst_next = if_inst;
          w_same_cnt_next  = '0;
          w_nop_cnt_next   = '0;
        end
        if ((w_same_cnt_next == SAME_W'(STALL_LIMIT)) ||
            (w_nop_cnt_next == NOP_W'(NOP_LIMIT))) begin
          w_halted_next = 1'b1;
          w_state_next  = S_ADDR;
        end
      end

      S_ADDR: begin
        w_lat_cnt_next = LAT_W'(RD_LAT);
        w_state_next   = S_WAIT;
      end

      S_WAIT: begin
        w_lat_cnt_next = r_lat_cnt - LAT_W'(1);
        if (r_lat_cnt == LAT_W'(1)) begin
          w_shift_next     = bus.con_out;
          w_csum_next      = r_csum + bus.con_out;
          w_out_data_next  = bus.con_out[31:24];
          w_out_valid_next = 1'b1;
          w_byte_idx_next  = 2'd3;
          w_state_next     = S_SEND;
        end
      end

      // The shift register holds the current word; the top byte is already on out_data.
      S_SEND, S_CSUM: begin
        if (w_accept) begin
          if (r_byte_idx != 2'd0) begin
            w_byte_idx_next = r_byte_idx - 2'd1;
            w_shift_next    = r_shift << 8;
            w_out_data_next = r_shift[23:16];
          end else if (r_state == S_CSUM) begin
            w_done_next      = 1'b1;
            w_out_valid_next = 1'b0;
            w_state_next     = S_DONE;
          end else if (r_addr == ADDR_W'(MAX_ADDR)) begin
            w_shift_next    = r_csum;
            w_out_data_next = r_csum[31:24];
            w_byte_idx_next = 2'd3;
            w_state_next    = S_CSUM;
          end else begin
            w_addr_next      = r_addr + ADDR_W'(1);
            w_out_valid_next = 1'b0;
            w_state_next     = S_ADDR;
          end
        end
      end

      S_DONE: begin
        w_state_next = S_DONE;
      end

      default: begin
        w_state_next = S_MON;
      end
    endcase
  end

  assign bus.con_addr  = r_addr;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign halted        = r_halted;
  assign dump_done     = r_done;
  assign dump_busy     = (r_state == S_ADDR) || (r_state == S_WAIT) ||
                         (r_state == S_SEND) || (r_state == S_CSUM);

endmodule

// File: tb/tb_con_dump_sequencer.sv
// Directed bench for con_dump_sequencer: halt detection timing and a 3-word dump
// with a 2-cycle console read latency.
module tb_con_dump_sequencer;

  logic        clk;
  logic        nrst;
  logic [31:0] if_inst;
  logic        halted;
  logic        dump_busy;
  logic        dump_done;
  logic [31:0] rd_d1;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_stream [16] = '{
    8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'hA5, 8'hA5, 8'hA5,
    8'h00, 8'h00, 8'h00, 8'h01, 8'hB6, 8'hC7, 8'hD8, 8'hEA
  };

  con_dump_sequencer_if #(.ADDR_W(14)) bus ();

  con_dump_sequencer #(
    .ADDR_W(14), .MAX_ADDR(2), .STALL_LIMIT(49), .NOP_LIMIT(16), .RD_LAT(2)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .if_inst   (if_inst),
    .bus       (bus.master),
    .halted    (halted),
    .dump_busy (dump_busy),
    .dump_done (dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [13:0] a);
    case (a)
      14'd0:   return 32'h1122_3344;
      14'd1:   return 32'hA5A5_A5A5;
      14'd2:   return 32'h0000_0001;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Two-stage read pipeline: con_out follows con_addr after two edges.
  always_ff @(posedge clk) begin
    rd_d1       <= mem_word(bus.con_addr);
    bus.con_out <= rd_d1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input logic [31:0] inst);
    nrst          = 1'b0;
    if_inst       = inst;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic wait_halt(input string tag);
    int c = 0;
    while (!halted && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    check(tag, {31'd0, halted}, 32'd1);
  endtask

  task automatic collect(input bit rand_ready, input int max_bytes, input string tag);
    int         n = 0;
    int         cyc = 0;
    bit         stalled = 1'b0;
    logic [7:0] sd = '0;
    logic [13:0] sa = '0;
    while (n < max_bytes && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        check($sformatf("%s_stall_valid", tag), {31'd0, bus.out_valid}, 32'd1);
        check($sformatf("%s_stall_data", tag), {24'd0, bus.out_data}, {24'd0, sd});
        check($sformatf("%s_stall_addr", tag), {18'd0, bus.con_addr}, {18'd0, sa});
      end
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = bus.out_valid && !bus.out_ready;
      sd = bus.out_data;
      sa = bus.con_addr;
      if (bus.out_valid && bus.out_ready) begin
        $display("%s byte %0d = %h", tag, n, bus.out_data);
        check($sformatf("%s_byte%0d", tag, n), {24'd0, bus.out_data}, {24'd0, exp_stream[n]});
        n++;
      end
    end
    check($sformatf("%s_count", tag), n, max_bytes);
  endtask

  initial begin
    bit saw_valid;
    bit saw_halt;

    nrst          = 1'b1;
    if_inst       = '0;
    bus.out_ready = 1'b0;
    #1 nrst = 1'b0;
    #1;
    check("rst_con_addr",  {18'd0, bus.con_addr}, 32'd0);
    check("rst_out_data",  {24'd0, bus.out_data}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_halted",    {31'd0, halted}, 32'd0);
    check("rst_busy",      {31'd0, dump_busy}, 32'd0);
    check("rst_done",      {31'd0, dump_done}, 32'd0);

    // Ever-changing instruction stream never halts.
    do_reset(32'h0000_0100);
    saw_valid = 1'b0;
    saw_halt  = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if_inst = if_inst + 32'd4;
      if (bus.out_valid) saw_valid = 1'b1;
      if (halted) saw_halt = 1'b1;
    end
    $display("increment run: halted seen %0b, valid seen %0b", saw_halt, saw_valid);
    check("inc_halted", {31'd0, saw_halt}, 32'd0);
    check("inc_valid",  {31'd0, saw_valid}, 32'd0);

    // NOP held: halt after edge 17, first byte after edge 20, full stream.
    do_reset(32'h0000_0013);
    repeat (16) @(posedge clk);
    #1;
    check("nop_halted_e16", {31'd0, halted}, 32'd0);
    check("nop_busy_e16",   {31'd0, dump_busy}, 32'd0);
    @(posedge clk);
    #1;
    check("nop_halted_e17", {31'd0, halted}, 32'd1);
    check("nop_busy_e17",   {31'd0, dump_busy}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("lat_valid_e19", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("lat_valid_e20", {31'd0, bus.out_valid}, 32'd1);
    check("lat_data_e20",  {24'd0, bus.out_data}, 32'h11);
    collect(1'b0, 16, "full");
    @(posedge clk);
    #1;
    if_inst = 32'h0000_1234;
    check("full_done",  {31'd0, dump_done}, 32'd1);
    check("full_valid", {31'd0, bus.out_valid}, 32'd0);
    check("full_busy",  {31'd0, dump_busy}, 32'd0);
    check("full_addr",  {18'd0, bus.con_addr}, 32'd2);
    repeat (5) @(posedge clk);
    #1;
    check("done_sticky", {31'd0, dump_done}, 32'd1);
    check("done_addr",   {18'd0, bus.con_addr}, 32'd2);

    // jal x0,0 held: halt after edge 50.
    do_reset(32'h0000_006F);
    repeat (49) @(posedge clk);
    #1;
    check("jal_halted_e49", {31'd0, halted}, 32'd0);
    @(posedge clk);
    #1;
    check("jal_halted_e50", {31'd0, halted}, 32'd1);

    // Repeating 0x13,0x13,0x6F never halts.
    do_reset(32'h0000_0013);
    saw_halt = 1'b0;
    for (int k = 1; k < 300; k++) begin
      @(negedge clk);
      if (halted) saw_halt = 1'b1;
      if_inst = (k % 3 == 2) ? 32'h0000_006F : 32'h0000_0013;
    end
    @(negedge clk);
    if (halted) saw_halt = 1'b1;
    $display("pattern run: halted seen %0b", saw_halt);
    check("pattern_halted", {31'd0, saw_halt}, 32'd0);

    // Random back-pressure: same bytes, stable across stalls.
    do_reset(32'h0000_0013);
    wait_halt("rnd_halt");
    collect(1'b1, 16, "rnd");
    @(posedge clk);
    #1;
    check("rnd_done", {31'd0, dump_done}, 32'd1);

    // Reset pulsed after the 6th accepted byte, then a full restart.
    do_reset(32'h0000_0013);
    wait_halt("mid_halt");
    collect(1'b0, 6, "part");
    @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    $display("async reset applied mid-dump");
    check("mid_con_addr",  {18'd0, bus.con_addr}, 32'd0);
    check("mid_out_data",  {24'd0, bus.out_data}, 32'd0);
    check("mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_halted",    {31'd0, halted}, 32'd0);
    check("mid_busy",      {31'd0, dump_busy}, 32'd0);
    check("mid_done",      {31'd0, dump_done}, 32'd0);
    do_reset(32'h0000_0013);
    wait_halt("re_halt");
    collect(1'b0, 16, "restart");
    @(posedge clk);
    #1;
    check("restart_done", {31'd0, dump_done}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
